req_dispatch_queue: RTL and testbench

Parametrised multi-channel request queue between the instruction deserializer and the crypto FSMs (AES, SHA, future cores). Each accepted instruction is routed by its opcode low bits into one of NCH independent first-word-fall-through FIFOs of depth QDEPTH. Every FIFO presents a standard valid/ready interface to its FSM. Back-pressure toward the deserializer is per-destination, so one busy core does not stall the others.

---
 rtl/req_queue_pkg.sv | 31 +++
 rtl/req_chan_fifo.sv | 86 ++++++++
 rtl/req_dispatch_queue.sv | 107 ++++++++++
 tb/tb_req_dispatch_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_queue_pkg.sv
// req_queue_pkg: shared sizing helpers and instruction field layout for the
// request dispatch queue.
//   instr_w  : packed instruction width {opcode, key_addr, text_addr}
//   chan_w   : channel-select width derived from the channel count
//   cnt_w    : per-channel occupancy counter width (holds 0..QDEPTH)
//   *_lsb    : bit positions of the instruction fields (text_addr at LSBs)
package req_queue_pkg;

  function automatic int instr_w(input int addrw, input int opcodew);
    return 2 * addrw + opcodew;
  endfunction

  function automatic int chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int cnt_w(input int qdepth);
    return $clog2(qdepth) + 1;
  endfunction

  localparam int TEXT_LSB = 0;

  function automatic int key_lsb(input int addrw);
    return addrw;
  endfunction

  function automatic int opc_lsb(input int addrw);
    return 2 * addrw;
  endfunction

endpackage

// File: rtl/req_chan_fifo.sv
// req_chan_fifo: one first-word-fall-through channel FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (memory cleared too)
//   flush_i    : synchronous clear of pointers and count, overrides push/pop
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : consume head entry (ignored when empty)
//   rdata_o    : head entry, combinational from memory and read pointer
//   valid_o    : channel not empty
//   full_o     : count == QDEPTH
//   count_o    : entries held, 0..QDEPTH
module req_chan_fifo
  import req_queue_pkg::*;
#(
  parameter int INSTRW = 18,
  parameter int QDEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [INSTRW-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [INSTRW-1:0]        rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [cnt_w(QDEPTH)-1:0] count_o
);

  localparam int PTRW = $clog2(QDEPTH);
  localparam int CNTW = cnt_w(QDEPTH);

  logic [INSTRW-1:0] mem_q [QDEPTH];
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]   count_q,  count_d;
  logic              full, empty, do_push, do_pop;

  assign full    = (count_q == CNTW'(QDEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign full_o  = full;
  assign count_o = count_q;

endmodule

// File: rtl/req_dispatch_queue.sv
// req_dispatch_queue: routes deserialized instructions by opcode[CHW-1:0]
// into NCH independent FWFT FIFOs, one per crypto core.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous clear of every channel
//   in_valid     : instruction offered; in_ready: target channel can accept
//   opcode, key_addr, text_addr : instruction fields
//   out_valid[c], out_ready[c]  : per-channel head handshake
//   out_instr    : head of channel c at slice c, {opcode, key_addr, text_addr}
//   occupancy    : entry count of channel c at slice c
// Optional (macro REQ_DISPATCH_STALL_CNT_EN):
//   stall_cnt    : saturating count of cycles with in_valid && !in_ready
//   ovf_seen     : sticky per-channel flag, push refused because channel full
module req_dispatch_queue
  import req_queue_pkg::*;
#(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2,
  parameter int QDEPTH  = 16,
  parameter int NCH     = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [OPCODEW-1:0]                       opcode,
  input  logic [ADDRW-1:0]                         key_addr,
  input  logic [ADDRW-1:0]                         text_addr,
  output logic [NCH-1:0]                           out_valid,
  input  logic [NCH-1:0]                           out_ready,
  output logic [NCH*instr_w(ADDRW, OPCODEW)-1:0]   out_instr,
`ifdef REQ_DISPATCH_STALL_CNT_EN
  output logic [15:0]                              stall_cnt,
  output logic [NCH-1:0]                           ovf_seen,
`endif
  output logic [NCH*cnt_w(QDEPTH)-1:0]             occupancy
);

  localparam int INSTRW = instr_w(ADDRW, OPCODEW);
  localparam int CHW    = chan_w(NCH);
  localparam int CNTW   = cnt_w(QDEPTH);

  logic [INSTRW-1:0] wdata;
  logic [CHW-1:0]    sel;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    push;
  logic              accept;

  assign wdata    = {opcode, key_addr, text_addr};
  assign sel      = opcode[CHW-1:0];
  assign in_ready = !full[sel] && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    push = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      push[c] = accept && (sel == CHW'(c));
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    req_chan_fifo #(
      .INSTRW (INSTRW),
      .QDEPTH (QDEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .push_i  (push[c]),
      .wdata_i (wdata),
      .pop_i   (out_ready[c]),
      .rdata_o (out_instr[c*INSTRW +: INSTRW]),
      .valid_o (out_valid[c]),
      .full_o  (full[c]),
      .count_o (occupancy[c*CNTW +: CNTW])
    );
  end

`ifdef REQ_DISPATCH_STALL_CNT_EN
  logic [15:0]    stall_q, stall_d;
  logic [NCH-1:0] ovf_q, ovf_d;

  // Counters survive flush: they describe deserializer back-pressure history.
  always_comb begin
    stall_d = stall_q;
    ovf_d   = ovf_q;
    if (in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (in_valid && (sel == CHW'(c)) && full[c]) ovf_d[c] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      ovf_q   <= '0;
    end else begin
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stall_cnt = stall_q;
  assign ovf_seen  = ovf_q;
`endif

endmodule

// File: tb/tb_req_dispatch_queue.sv
module tb_req_dispatch_queue;

  localparam int IW = 18;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    opcode;
  logic [7:0]    key_addr;
  logic [7:0]    text_addr;
  logic [1:0]    out_valid;
  logic [1:0]    out_ready;
  logic [2*IW-1:0] out_instr;
  logic [2*CW-1:0] occupancy;
`ifdef REQ_DISPATCH_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  logic [1:0]    ovf_seen;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  req_dispatch_queue #(
    .ADDRW   (8),
    .OPCODEW (2),
    .QDEPTH  (16),
    .NCH     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .key_addr  (key_addr),
    .text_addr (text_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
`ifdef REQ_DISPATCH_STALL_CNT_EN
    .stall_cnt (stall_cnt),
    .ovf_seen  (ovf_seen),
`endif
    .occupancy (occupancy)
  );

  function automatic logic [IW-1:0] head(input int c);
    return out_instr[c*IW +: IW];
  endfunction

  function automatic logic [CW-1:0] occ(input int c);
    return occupancy[c*CW +: CW];
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] k, input logic [7:0] t);
    opcode = op; key_addr = k; text_addr = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = '0;
    drive(2'b00, 8'h00, 8'h00);
    go(); go();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
    checks++;
    if (occupancy !== '0) begin failures++; $display("FAIL reset_occupancy got=%h exp=0", occupancy); end
    checks++;
    if (out_instr !== '0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    rst_n = 1'b1;
    go();
  endtask

  task automatic test_single_push();
    drive(2'b01, 8'hA5, 8'h3C); in_valid = 1'b1;
    go();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 2'b10) begin failures++; $display("FAIL push_out_valid got=%b exp=10", out_valid); end
    checks++;
    if (head(1) !== 18'h1A53C) begin failures++; $display("FAIL push_head1 got=%h exp=1a53c", head(1)); end
    checks++;
    if (occ(0) !== 5'd0 || occ(1) !== 5'd1) begin failures++; $display("FAIL push_occ got=%h exp=020", occupancy); end
    out_ready = 2'b10;
    go();
    out_ready = 2'b00;
    checks++;
    if (out_valid !== 2'b00) begin failures++; $display("FAIL pop_out_valid got=%b exp=00", out_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 8'(i), 8'(8'hF0 + i)); in_valid = 1'b1;
      go();
    end
    in_valid = 1'b0;
    checks++;
    if (occ(0) !== 5'd16) begin failures++; $display("FAIL fill_occ0 got=%0d exp=16", occ(0)); end
    opcode = 2'b00; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_ch0 got=%b exp=0", in_ready); end
    opcode = 2'b01; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_ch1 got=%b exp=1", in_ready); end
    drive(2'b00, 8'hEE, 8'hEE); in_valid = 1'b1;
    go();
    exp_stall++;
    in_valid = 1'b0;
    checks++;
    if (occ(0) !== 5'd16) begin failures++; $display("FAIL refuse_occ0 got=%0d exp=16", occ(0)); end
    checks++;
    if (head(0) !== 18'h000F0) begin failures++; $display("FAIL refuse_head0 got=%h exp=000f0", head(0)); end
`ifdef REQ_DISPATCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL refuse_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++;
    if (ovf_seen !== 2'b01) begin failures++; $display("FAIL refuse_ovf got=%b exp=01", ovf_seen); end
`endif
  endtask

  task automatic test_full_pop_push();
    drive(2'b00, 8'h77, 8'h88); in_valid = 1'b1; out_ready = 2'b01;
    go();
    exp_stall++;
    out_ready = 2'b00;
    checks++;
    if (occ(0) !== 5'd15) begin failures++; $display("FAIL fullpop_occ0 got=%0d exp=15", occ(0)); end
    checks++;
    if (head(0) !== 18'h001F1) begin failures++; $display("FAIL fullpop_head0 got=%h exp=001f1", head(0)); end
    go();
    in_valid = 1'b0;
    checks++;
    if (occ(0) !== 5'd16) begin failures++; $display("FAIL fullpush_occ0 got=%0d exp=16", occ(0)); end
    out_ready = 2'b01;
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (head(0) !== {2'b00, 8'(i), 8'(8'hF0 + i)})
        begin failures++; $display("FAIL drain_head0[%0d] got=%h exp=%h", i, head(0), {2'b00, 8'(i), 8'(8'hF0 + i)}); end
      go();
    end
    checks++;
    if (head(0) !== 18'h07788) begin failures++; $display("FAIL drain_last got=%h exp=07788", head(0)); end
    go();
    out_ready = 2'b00;
    checks++;
    if (out_valid !== 2'b00) begin failures++; $display("FAIL drain_empty got=%b exp=00", out_valid); end
`ifdef REQ_DISPATCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL fullpop_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
`endif
  endtask

  task automatic test_wrap();
    logic [IW-1:0] q[$];
    logic [IW-1:0] d;
    logic [1:0]    op;
    for (int k = 0; k < 3; k++) begin
      d = {2'b01, 8'(8'h50 + k), 8'(8'h60 + k)};
      drive(d[17:16], d[15:8], d[7:0]); in_valid = 1'b1;
      go();
      q.push_back(d);
    end
    out_ready = 2'b10;
    for (int k = 0; k < 40; k++) begin
      op = (k % 2 == 1) ? 2'b11 : 2'b01;
      d = {op, 8'(k), 8'(k * 3)};
      drive(d[17:16], d[15:8], d[7:0]);
      checks++;
      if (head(1) !== q[0]) begin failures++; $display("FAIL wrap_head[%0d] got=%h exp=%h", k, head(1), q[0]); end
      go();
      void'(q.pop_front());
      q.push_back(d);
    end
    in_valid = 1'b0;
    checks++;
    if (occ(1) !== 5'd3) begin failures++; $display("FAIL wrap_occ1 got=%0d exp=3", occ(1)); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (head(1) !== q[0]) begin failures++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", k, head(1), q[0]); end
      go();
      void'(q.pop_front());
    end
    out_ready = 2'b00;
    checks++;
    if (out_valid !== 2'b00) begin failures++; $display("FAIL wrap_empty got=%b exp=00", out_valid); end
  endtask

  task automatic test_flush();
    drive(2'b00, 8'h11, 8'h22); in_valid = 1'b1; go();
    drive(2'b00, 8'h33, 8'h44); go();
    drive(2'b01, 8'h55, 8'h66); go();
    drive(2'b00, 8'h99, 8'hAA); flush = 1'b1; out_ready = 2'b11;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    go();
    exp_stall++;
    flush = 1'b0; in_valid = 1'b0; out_ready = 2'b00;
    checks++;
    if (occupancy !== '0) begin failures++; $display("FAIL flush_occ got=%h exp=0", occupancy); end
    checks++;
    if (out_valid !== 2'b00) begin failures++; $display("FAIL flush_out_valid got=%b exp=00", out_valid); end
`ifdef REQ_DISPATCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL flush_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
`endif
    drive(2'b00, 8'hC3, 8'h5A); in_valid = 1'b1; go();
    in_valid = 1'b0;
    checks++;
    if (head(0) !== 18'h0C35A || occ(0) !== 5'd1)
      begin failures++; $display("FAIL postflush_head0 got=%h/%0d exp=0c35a/1", head(0), occ(0)); end
    out_ready = 2'b01; go(); out_ready = 2'b00;
  endtask

  task automatic test_async_reset();
    drive(2'b01, 8'h12, 8'h34); in_valid = 1'b1; go();
    drive(2'b00, 8'h56, 8'h78); go();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 2'b00) begin failures++; $display("FAIL arst_out_valid got=%b exp=00", out_valid); end
    checks++;
    if (occupancy !== '0) begin failures++; $display("FAIL arst_occ got=%h exp=0", occupancy); end
    checks++;
    if (out_instr !== '0) begin failures++; $display("FAIL arst_out_instr got=%h exp=0", out_instr); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
`ifdef REQ_DISPATCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0 || ovf_seen !== 2'b00)
      begin failures++; $display("FAIL arst_counters got=%0d/%b exp=0/00", stall_cnt, ovf_seen); end
`endif
    exp_stall = 0;
    go();
    rst_n = 1'b1;
    go();
    drive(2'b01, 8'hDE, 8'hAD); in_valid = 1'b1; go();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 2'b10 || head(1) !== 18'h1DEAD)
      begin failures++; $display("FAIL arst_repush got=%b/%h exp=10/1dead", out_valid, head(1)); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_full_pop_push();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
